// File: rtl/display_pkg.sv
// display_pkg: shared state encoding, default sizing and leading-zero mask for the display scanner.
package display_pkg;
  localparam int DIGITS_DEF = 4;
  localparam int PRESCALE_DEF = 50000;
  localparam int BLANK_DEF = 16;
  localparam int MAX_DIGITS = 16;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_e;
  // Bit k set when nibbles k..top are all zero; digit 0 is never suppressed.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value);
    logic zero_above;
    zero_above = 1'b1;
    lz_mask = '0;
    for (int k = MAX_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (value[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  endfunction
endpackage

// File: rtl/slot_timer.sv
// slot_timer: per-slot cycle counter with blank-end and slot-end strobes.
// Ports: clk, rst_n (async, active-low), clr_i (sync clear), run_i (count enable),
//        cnt_o (cycle within slot), blank_done_o (last blank cycle), slot_done_o (last slot cycle).
module slot_timer #(
  parameter int PRESCALE = 8,
  parameter int BLANK = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        run_i,
  output logic [$clog2(PRESCALE)-1:0] cnt_o,
  output logic                        blank_done_o,
  output logic                        slot_done_o
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_o = cnt_q;
  assign slot_done_o = cnt_q == CW'(PRESCALE - 1);
  assign blank_done_o = (BLANK != 0) && (cnt_q == CW'(BLANK - 1));
  always_comb cnt_d = clr_i ? '0 : !run_i ? cnt_q : slot_done_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/display_scanner.sv
// display_scanner: multiplexed seven-segment scan controller with blanking, leading-zero suppression and frame-synchronous loads.
// Ports: clk, rst_n (async, active-low), enable_i, load_i/value_i/dp_i (value strobe), lz_blank_i,
//        nibble_o/dp_o (current digit to decoder), digit_en_o (active-low anodes), frame_o (last cycle of frame).
module display_scanner import display_pkg::*; #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lz_blank_i,
  output logic [3:0]            nibble_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  frame_o
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
  localparam state_e SLOT_START = BLANK == 0 ? S_SHOW : S_BLANK;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d, digit_en_q, digit_en_d;
  logic pend_vld_q, pend_vld_d, dp_q, dp_d, frame_q, frame_d;
  logic [3:0] nibble_q, nibble_d;
  logic [CW-1:0] slot_cnt;
  logic blank_done, slot_done, wrap;
  logic [4*MAX_DIGITS-1:0] wide;
  logic [MAX_DIGITS-1:0] sup;
  slot_timer #(.PRESCALE(PRESCALE), .BLANK(BLANK)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (!enable_i),
    .run_i        (state_q != S_IDLE),
    .cnt_o        (slot_cnt),
    .blank_done_o (blank_done),
    .slot_done_o  (slot_done)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    act_val_d = act_val_q;
    act_dp_d = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d = pend_dp_q;
    pend_vld_d = pend_vld_q;
    wrap = enable_i && state_q == S_SHOW && slot_done && idx_q == LAST_DIGIT;
    if (!enable_i) begin
      state_d = S_IDLE;
      idx_d = '0;
    end else if (state_q == S_IDLE) state_d = SLOT_START;
    else if (state_q == S_BLANK && blank_done) state_d = S_SHOW;
    else if (state_q == S_SHOW && slot_done) begin
      state_d = SLOT_START;
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    if (pend_vld_q && (wrap || state_q == S_IDLE)) begin
      act_val_d = pend_val_q;
      act_dp_d = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    // A load landing on the frame wrap bypasses pending so the new frame shows it at once.
    if (load_i && wrap) begin
      act_val_d = value_i;
      act_dp_d = dp_i;
      pend_vld_d = 1'b0;
    end else if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d = dp_i;
      pend_vld_d = 1'b1;
    end
    wide = '0;
    wide[4*DIGITS-1:0] = act_val_d;
    sup = lz_mask(wide);
    nibble_d = act_val_d[4*idx_d +: 4];
    dp_d = act_dp_d[idx_d];
    digit_en_d = '1;
    if (state_d == S_SHOW && !(lz_blank_i && sup[idx_d])) digit_en_d[idx_d] = 1'b0;
    // Counter at PRESCALE-2 means the next cycle is the slot's final SHOW cycle.
    frame_d = enable_i && state_q != S_IDLE && idx_q == LAST_DIGIT && slot_cnt == CW'(PRESCALE - 2);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      act_val_q <= '0;
      act_dp_q <= '0;
      pend_val_q <= '0;
      pend_dp_q <= '0;
      pend_vld_q <= 1'b0;
      nibble_q <= '0;
      dp_q <= 1'b0;
      digit_en_q <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      nibble_q <= nibble_d;
      dp_q <= dp_d;
      digit_en_q <= digit_en_d;
      frame_q <= frame_d;
    end
  assign nibble_o = nibble_q;
  assign dp_o = dp_q;
  assign digit_en_o = digit_en_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed self-checking bench for display_scanner (BLANK=2 and BLANK=0 instances).
module tb_display_scanner;
  logic clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, en2 = 1'b0, load_i = 1'b0, lz_blank_i = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0] dp_i = '0;
  logic [3:0] nib, nib2, den, den2;
  logic dp, dp2, frm, frm2;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  display_scanner #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .load_i(load_i), .value_i(value_i), .dp_i(dp_i),
    .lz_blank_i(lz_blank_i), .nibble_o(nib), .dp_o(dp), .digit_en_o(den), .frame_o(frm)
  );
  display_scanner #(.DIGITS(4), .PRESCALE(8), .BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .load_i(load_i), .value_i(value_i), .dp_i(dp_i),
    .lz_blank_i(lz_blank_i), .nibble_o(nib2), .dp_o(dp2), .digit_en_o(den2), .frame_o(frm2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_idle(input logic [15:0] v, input logic [3:0] d);
    value_i = v;
    dp_i = d;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    logic [9:0] got;
    repeat (3) tick();
    checks++;
    got = {den, nib, dp, frm};
    if (got !== 10'b1111_0000_0_0) begin fails++; $display("FAIL reset_hold got %b want %b", got, 10'b1111_0000_0_0); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      got = {den, nib, dp, frm};
      if (got !== 10'b1111_0000_0_0 || den2 !== 4'hF || frm2 !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_reset cyc %0d got %b den2 %b want %b den2 1111", i, got, den2, 10'b1111_0000_0_0);
      end
    end
  endtask
  task automatic test_basic();
    logic [15:0] v;
    logic [3:0] oh;
    logic [9:0] got, exp;
    v = 16'h1A3F;
    load_idle(v, 4'b0100);
    enable_i = 1'b1;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 8; c++) begin
        tick();
        oh = 4'b0001 << (s % 4);
        exp = {(c < 2) ? 4'hF : ~oh, v[4*(s%4) +: 4], dp_i[s%4], (s % 4 == 3) && (c == 7)};
        got = {den, nib, dp, frm};
        checks++;
        if (got !== exp) begin fails++; $display("FAIL basic_scan slot %0d cyc %0d got %b want %b", s, c, got, exp); end
      end
    enable_i = 1'b0;
    tick();
    checks++;
    got = {den, nib, dp, frm};
    if (got !== 10'b1111_1111_0_0) begin fails++; $display("FAIL basic_disable got %b want %b", got, 10'b1111_1111_0_0); end
  endtask
  task automatic test_lz();
    logic [15:0] v;
    logic [3:0] oh;
    logic [9:0] got, exp;
    lz_blank_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      v = (r == 0) ? 16'h0050 : 16'h0000;
      load_idle(v, 4'b0000);
      enable_i = 1'b1;
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 8; c++) begin
          tick();
          oh = 4'b0001 << s;
          exp = {(c < 2 || s > ((r == 0) ? 1 : 0)) ? 4'hF : ~oh, v[4*s +: 4], 1'b0, (s == 3) && (c == 7)};
          got = {den, nib, dp, frm};
          checks++;
          if (got !== exp) begin fails++; $display("FAIL lz_blank run %0d slot %0d cyc %0d got %b want %b", r, s, c, got, exp); end
        end
      enable_i = 1'b0;
      tick();
    end
    lz_blank_i = 1'b0;
  endtask
  task automatic test_frame_sync();
    logic [3:0] oh, en;
    logic [9:0] got, exp;
    load_idle(16'h1111, 4'b0000);
    enable_i = 1'b1;
    for (int s = 0; s < 12; s++)
      for (int c = 0; c < 8; c++) begin
        tick();
        load_i = 1'b0;
        oh = 4'b0001 << (s % 4);
        en = (c < 2) ? 4'hF : ~oh;
        exp = {en, (s < 4) ? 4'h1 : (s < 8) ? 4'h2 : 4'h3, 1'b0, (s % 4 == 3) && (c == 7)};
        got = {den, nib, dp, frm};
        checks++;
        if (got !== exp) begin fails++; $display("FAIL frame_sync slot %0d cyc %0d got %b want %b", s, c, got, exp); end
        if (s == 1 && c == 4) begin value_i = 16'h2222; load_i = 1'b1; end
        if (s == 7 && c == 7) begin value_i = 16'h3333; load_i = 1'b1; end
      end
    enable_i = 1'b0;
    tick();
  endtask
  task automatic test_enable_drop();
    logic [9:0] got;
    load_idle(16'h1A3F, 4'b0000);
    enable_i = 1'b1;
    repeat (21) tick();
    checks++;
    if (den !== 4'b1011) begin fails++; $display("FAIL drop_pre den got %b want %b", den, 4'b1011); end
    enable_i = 1'b0;
    tick();
    checks++;
    got = {den, nib, dp, frm};
    if (got !== 10'b1111_1111_0_0) begin fails++; $display("FAIL drop_idle got %b want %b", got, 10'b1111_1111_0_0); end
    enable_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      got = {den, nib, dp, frm};
      if (got !== {(c < 2) ? 4'hF : 4'hE, 4'hF, 2'b00}) begin
        fails++;
        $display("FAIL reenable cyc %0d got %b want %b", c, got, {(c < 2) ? 4'hF : 4'hE, 4'hF, 2'b00});
      end
    end
    value_i = 16'h7777;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    got = {den, nib, dp, frm};
    if (got !== 10'b1111_0000_0_0) begin fails++; $display("FAIL async_reset got %b want %b", got, 10'b1111_0000_0_0); end
    enable_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    enable_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      got = {den, nib, dp, frm};
      if (got !== {(c < 2) ? 4'hF : 4'hE, 4'h0, 2'b00}) begin
        fails++;
        $display("FAIL post_reset_scan cyc %0d got %b want %b", c, got, {(c < 2) ? 4'hF : 4'hE, 4'h0, 2'b00});
      end
    end
    enable_i = 1'b0;
    tick();
  endtask
  task automatic test_blank0();
    logic [3:0] oh;
    logic [8:0] got, exp;
    load_idle(16'h4321, 4'b0000);
    en2 = 1'b1;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 8; c++) begin
        tick();
        oh = 4'b0001 << (s % 4);
        exp = {~oh, 4'((s % 4) + 1), (s % 4 == 3) && (c == 7)};
        got = {den2, nib2, frm2};
        checks++;
        if (got !== exp) begin fails++; $display("FAIL blank0 slot %0d cyc %0d got %b want %b", s, c, got, exp); end
      end
    en2 = 1'b0;
    tick();
    checks++;
    if (den2 !== 4'hF) begin fails++; $display("FAIL blank0_disable den2 got %b want %b", den2, 4'hF); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_frame_sync();
    test_enable_drop();
    test_blank0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan controller for a common-anode, multi-digit seven-segment display. It holds a multi-digit hexadecimal value and cycles through the digits at a programmable slot rate. For each slot it drives the selected 4-bit nibble into the existing hex-to-seven-segment decoder and asserts that digit's anode enable. It sits directly upstream of the decoder, with an anti-ghosting blank interval, leading-zero blanking and frame-synchronous value updates.

## Interface
- `DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `PRESCALE`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, default 16: cycles at the start of each slot with all anodes off; 0 ≤ BLANK < PRESCALE.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable_i` in 1: scan enable; low forces the idle state.
- `load_i` in 1: single-cycle strobe that captures `value_i` and `dp_i`.
- `value_i` in 4·DIGITS: nibble k is digit k; digit 0 is least significant.
- `dp_i` in DIGITS: per-digit decimal-point request.
- `lz_blank_i` in 1: leading-zero blanking enable; sampled every cycle.
- `nibble_o` out 4: nibble of the current digit, fed to the decoder's 4-bit input.
- `dp_o` out 1: decimal point of the current digit; active-high.
- `digit_en_o` out DIGITS: anode enables, active-low; at most one bit is low at any time.
- `frame_o` out 1: one-cycle pulse in the last cycle of each frame.

## Operation
- FSM states:
  - IDLE: all anodes off.
  - BLANK: all anodes off; `nibble_o`/`dp_o` already show the current digit.
  - SHOW: the current digit's anode is low unless the digit is suppressed.
- Transitions:
  - IDLE→BLANK when `enable_i`=1. If BLANK=0, IDLE→SHOW instead.
  - BLANK→SHOW after BLANK cycles.
  - SHOW→BLANK (or SHOW→SHOW when BLANK=0) after PRESCALE−BLANK cycles, with digit index +1.
  - Digit index wraps from DIGITS−1 to 0.
  - Any state→IDLE on the cycle after `enable_i`=0. On entering IDLE, the slot counter and digit index clear to 0.
- Two value registers:
  - pending (value, dp): loaded by `load_i`.
  - active: drives the outputs.
- Transfer from pending to active:
  - At every frame boundary (the wrap to digit 0), if pending is marked valid, pending is copied to active and the valid mark is cleared.
  - While in IDLE, transfer happens immediately on the cycle after a load.
  - If `load_i` coincides with a frame boundary, the `value_i` presented that cycle goes directly to active.
  - A load mid-frame never alters the digits remaining in the current frame, so no torn display.
- Leading-zero suppression:
  - Digit k is suppressed when `lz_blank_i`=1, k ≠ 0, and active nibbles k..DIGITS−1 are all zero.
  - A suppressed digit keeps its anode high for the whole slot.
  - `dp_o` of a suppressed digit is not forced low.
- `frame_o` pulses in the last SHOW cycle of digit DIGITS−1. It does not pulse while in IDLE.
- Reset mid-scan: all outputs and state return to their reset values immediately; the pending valid mark is cleared.

## Timing
- Reset values:
  - `digit_en_o` = all 1s.
  - `nibble_o` = 0.
  - `dp_o` = 0.
  - `frame_o` = 0.
  - Active and pending registers = 0; pending valid = 0.
  - State = IDLE, digit index = 0, slot counter = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- First anode asserts BLANK+1 cycles after `enable_i` rises; this is 1 cycle when BLANK=0.
- Slot length is exactly PRESCALE cycles; frame length is DIGITS·PRESCALE cycles.
- Digit order per frame is 0, 1, …, DIGITS−1.
- `nibble_o`/`dp_o` change only on the first cycle of a slot, which is the BLANK entry. They are stable for the whole slot.
- A value loaded mid-frame first appears on digit 0 of the next frame.
- Counter widths are $clog2 of their maximum count. The slot counter wraps exactly at PRESCALE−1 and never overflows.

## Structure
- Package `display_pkg` holds:
  - the FSM state enum {IDLE, BLANK, SHOW};
  - default constants for DIGITS, PRESCALE and BLANK;
  - a function that computes the leading-zero mask from the active value.
- Sub-module `slot_timer` contains the PRESCALE/BLANK counter. It emits `blank_done` and `slot_done` strobes and has a synchronous clear used when entering IDLE.
- The top level holds the FSM, digit index, pending/active registers and output registers. It instantiates the existing decoder only in integration, not inside this block.

## Test plan
Scenarios use PRESCALE=8, BLANK=2, DIGITS=4 unless noted.
1. **Reset and idle:** hold `rst_n`=0, then release with `enable_i`=0 → `digit_en_o`=4'b1111, `nibble_o`=0 and `frame_o`=0 indefinitely.
2. **Basic scan:** load 16'h1A3F, then raise `enable_i`.
   - Each slot gives 2 cycles of 4'b1111, then 6 cycles of 4'b1110/1101/1011/0111.
   - `nibble_o` sequence is F, 3, A, 1.
   - `frame_o` pulses every 32 cycles.
3. **Leading-zero blanking:** load 16'h0050 with `lz_blank_i`=1 → digits 3 and 2 keep their anodes high; digits 1 (nibble 5) and 0 (nibble 0) are shown. Repeat with 16'h0000 → only digit 0 is lit, showing 0.
4. **Frame-synchronous load:**
   - Mid-frame (during digit 1), load 16'h2222 over 16'h1111 → digits 2 and 3 still show 1; the next frame shows all 2.
   - `load_i` on the frame-boundary cycle → the new value appears from digit 0 of the frame starting then.
5. **Enable drop and async reset:**
   - Drop `enable_i` during SHOW of digit 2 → next cycle `digit_en_o`=4'b1111 and the index is 0.
   - Re-enable → scan restarts at digit 0 after 2 blank cycles.
   - Assert `rst_n`=0 mid-SHOW → outputs go to reset values without waiting for a clock edge.
6. **BLANK=0 corner:** with BLANK=0 → no all-off cycles between slots, exactly one anode low every cycle while enabled, and the first anode asserts 1 cycle after `enable_i` rises.
